seq_piso_serializer: RTL and testbench
======================================

// Module: seq_piso_serializer
// PURPOSE
//   Parallel-in serial-out feeder for the serial sequence-detector stage.
//   - Accepts WIDTH-bit words on a valid/ready handshake.
//   - Emits each word one bit per clock, MSB first, on x_out/x_valid.
//   - x_out drives the detector's serial input x directly.
//   - x_last marks the final bit of each frame.
// PARAMETERS
//   WIDTH  8  data bits per word; legal range >= 2
// PORTS
//   clk       in   1      single clock; all logic on its rising edge
//   rst       in   1      synchronous reset, active-high
//   in_data   in   WIDTH  parallel word; sampled on handshake
//   in_valid  in   1      source has a word on in_data
//   in_ready  out  1      block can accept a word this cycle
//   x_out     out  1      serial bit to downstream detector
//   x_valid   out  1      x_out carries a frame bit this cycle
//   x_last    out  1      x_out is the last bit of the current frame
// BEHAVIOUR
//   - Reset: state=IDLE; x_out=0, x_valid=0, x_last=0; shift register and
//     bit counter cleared. in_ready=1 in the first cycle after reset.
//   - Frame length: FL = WIDTH, or WIDTH+1 with parity (see CONFIGURATION).
//   - Bit counter width: $clog2(FL+1).
//   - Outputs x_out, x_valid and x_last are registered.
//   - in_ready is combinational:
//       in_ready = (state==IDLE) | (state==SHIFT & x_last)
//   - Transfer = in_valid & in_ready. in_data is captured only on a transfer.
//     With in_ready low, in_valid is ignored and the source holds its word.
//   - Latency: first bit of a word (MSB) appears one cycle after its transfer.
//     Bits follow MSB..LSB on consecutive cycles, x_valid high throughout.
//     There is no downstream stall.
//   - FSM states:
//       IDLE : x_valid=0, x_out=0.
//              On transfer -> SHIFT, load word, count=0.
//       SHIFT: present the current bit, count++.
//              On the bit where count==FL-1, x_last=1. In that same cycle:
//                - transfer -> reload and stay in SHIFT. Back-to-back frames
//                  have no gap; the next MSB follows the last bit directly.
//                - no transfer -> IDLE.
//   - Gaps: when the source idles, x_valid drops and x_out returns to 0.
//     The detector therefore sees 0s in gaps; this is acceptable by design.
//   - Reset mid-frame: the frame is aborted. On the next cycle x_valid=0 and
//     state=IDLE. No partial bits follow.
//   - Reset together with in_valid: reset wins and the word is not accepted.
//   - x_last is high for exactly one cycle per frame, always with x_valid.
// CONFIGURATION
//   SEQ_PISO_PARITY_EN
//   - Defined:
//       - One even-parity bit (^in_data of the captured word) is appended
//         after the LSB, so FL=WIDTH+1.
//       - x_last is asserted on the parity bit, not on the LSB.
//   - Undefined: FL=WIDTH and no parity logic is synthesized.
//   - The handshake rules are identical in both builds.
// TESTING
//   1. Reset, then in_data=8'hB6 for one transfer:
//      - x_out = 1,0,1,1,0,1,1,0 on cycles 1..8 after the transfer.
//      - x_valid high on all 8 cycles; x_last only on cycle 8.
//   2. Two words 8'hB6 then 8'h0B with in_valid held high:
//      - 16 contiguous x_valid cycles.
//      - in_ready high at idle and on bit 8 only.
//      - Second MSB immediately follows the first frame's LSB.
//   3. in_valid asserted with 8'hFF on bit 3 of a frame:
//      - in_ready=0 and the word is not captured.
//      - Current frame completes unchanged.
//      - 8'hFF is accepted on the x_last cycle.
//   4. rst pulsed on bit 4 of 8'hB6:
//      - Next cycle x_valid=0, x_out=0, x_last=0, in_ready=1.
//      - No further bits of 8'hB6 appear.
//   5. Build with SEQ_PISO_PARITY_EN, send 8'hB6 (five 1s):
//      - 9 bits: 1,0,1,1,0,1,1,0,1.
//      - x_last on bit 9; bit 8 has x_last=0.
//      - Repeat with 8'h03: parity bit is 0.
//   6. WIDTH=4, in_data=4'hB:
//      - x_out = 1,0,1,1 with x_last on bit 4.
//      - Downstream detector asserts z one cycle after the last bit.

Source files
------------

// File: rtl/seq_piso_serializer.sv
// seq_piso_serializer
//   Parallel-in serial-out feeder for the serial sequence-detector stage.
//   Words arrive on a valid/ready handshake. Each word is shifted out MSB
//   first, one bit per clock, on x_out with x_valid. x_last flags the final
//   bit of every frame. Back-to-back words produce gap-free frames.
//
//   Optional build macro: SEQ_PISO_PARITY_EN
//     When defined, an even-parity bit (^ of the captured word) is appended
//     after the LSB and x_last moves onto that parity bit.
//
// Parameters
//   WIDTH     data bits per word (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_data   parallel word, captured on in_valid & in_ready
//   in_valid  source has a word on in_data
//   in_ready  block can accept a word this cycle (combinational)
//   x_out     registered serial bit to the detector
//   x_valid   registered, x_out carries a frame bit
//   x_last    registered, x_out is the final bit of the frame

module seq_piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last
);

`ifdef SEQ_PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);

  // Counter value of the bit just before the last one; reaching it means the
  // bit registered next is the final bit of the frame.
  localparam logic [CW-1:0] PRE_LAST = CW'(FL - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [FL-1:0]   sreg_p0, sreg_nxt;
  logic [CW-1:0]   cnt_p0, cnt_nxt;
  logic            x_out_nxt, x_valid_nxt, x_last_nxt;
  logic            xfer;
  logic [FL-1:0]   word;

  // Builds the frame image for a captured word, MSB at the top.
  function automatic logic [FL-1:0] frame_word(input logic [WIDTH-1:0] d);
`ifdef SEQ_PISO_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  assign in_ready = (state == IDLE) | ((state == SHIFT) & x_last);
  assign xfer     = in_valid & in_ready;
  assign word     = frame_word(in_data);

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg_p0;
    cnt_nxt     = cnt_p0;
    x_out_nxt   = 1'b0;
    x_valid_nxt = 1'b0;
    x_last_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt   = SHIFT;
          x_out_nxt   = word[FL-1];
          x_valid_nxt = 1'b1;
          sreg_nxt    = word << 1;
          cnt_nxt     = '0;
        end
      end

      SHIFT: begin
        if (x_last) begin
          // Final bit is on the wire: either chain the next word with no
          // gap, or fall back to idle with the outputs parked at zero.
          if (xfer) begin
            x_out_nxt   = word[FL-1];
            x_valid_nxt = 1'b1;
            sreg_nxt    = word << 1;
            cnt_nxt     = '0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          x_out_nxt   = sreg_p0[FL-1];
          x_valid_nxt = 1'b1;
          x_last_nxt  = (cnt_p0 == PRE_LAST);
          sreg_nxt    = sreg_p0 << 1;
          cnt_nxt     = cnt_p0 + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p0: state, shift register, counter and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg_p0 <= '0;
      cnt_p0  <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      x_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg_p0 <= sreg_nxt;
      cnt_p0  <= cnt_nxt;
      x_out   <= x_out_nxt;
      x_valid <= x_valid_nxt;
      x_last  <= x_last_nxt;
    end
  end

endmodule

// File: tb/tb_seq_piso_serializer.sv
module tb_seq_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       x_out, x_valid, x_last;

  logic [3:0] in_data4;
  logic       in_valid4;
  logic       in_ready4;
  logic       x_out4, x_valid4, x_last4;

  int total = 0;
  int bad   = 0;

  // Hand-computed frame images, MSB first.
`ifdef SEQ_PISO_PARITY_EN
  localparam int          FL   = 9;
  localparam logic [15:0] P_B6 = 16'b1_0110_1101;  // B6 has five 1s -> parity 1
  localparam logic [15:0] P_0B = 16'b0_0001_0111;  // 0B has three 1s -> parity 1
  localparam logic [15:0] P_FF = 16'b1_1111_1110;  // FF has eight 1s -> parity 0
  localparam logic [15:0] P_03 = 16'b0_0000_0110;  // 03 has two 1s -> parity 0
  localparam int          FL4  = 5;
  localparam logic [15:0] P4_B = 16'b1_0111;       // B has three 1s -> parity 1
`else
  localparam int          FL   = 8;
  localparam logic [15:0] P_B6 = 16'h00B6;
  localparam logic [15:0] P_0B = 16'h000B;
  localparam logic [15:0] P_FF = 16'h00FF;
  localparam logic [15:0] P_03 = 16'h0003;
  localparam int          FL4  = 4;
  localparam logic [15:0] P4_B = 16'h000B;
`endif

  seq_piso_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out), .x_valid(x_valid), .x_last(x_last)
  );

  seq_piso_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .x_out(x_out4), .x_valid(x_valid4), .x_last(x_last4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting at the current sample point. If raise_at
  // is a bit index, in_valid is raised with nxt on that bit of the frame.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int n,
                             input int raise_at, input logic [7:0] nxt);
    for (int i = 0; i < n; i++) begin
      if (i == raise_at) begin
        in_valid = 1'b1;
        in_data  = nxt;
      end
      chk($sformatf("%s_xv%0d", tag, i), 16'(x_valid), 16'd1);
      chk($sformatf("%s_xo%0d", tag, i), 16'(x_out), 16'(bits[n-1-i]));
      chk($sformatf("%s_xl%0d", tag, i), 16'(x_last), 16'(i == n - 1));
      chk($sformatf("%s_rdy%0d", tag, i), 16'(in_ready), 16'(i == n - 1));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_xv"}, 16'(x_valid), 16'd0);
    chk({tag, "_xo"}, 16'(x_out), 16'd0);
    chk({tag, "_xl"}, 16'(x_last), 16'd0);
    chk({tag, "_rdy"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data4  = 4'h0;
    in_valid4 = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_idle("reset");

    // Single word B6
    in_data  = 8'hB6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame("single", P_B6, FL, -1, 8'h00);
    check_idle("single_end");

    // Back-to-back B6 then 0B with in_valid held
    in_data  = 8'hB6;
    in_valid = 1'b1;
    chk("b2b_rdy_idle", 16'(in_ready), 16'd1);
    step();
    in_data = 8'h0B;
    check_frame("b2b_a", P_B6, FL, 0, 8'h0B);
    check_frame("b2b_b", P_0B, FL, -1, 8'h00);
    check_idle("b2b_end");

    // FF offered mid-frame on bit 3, must wait for the x_last cycle
    in_data  = 8'hB6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame("hold_a", P_B6, FL, 2, 8'hFF);
    check_frame("hold_b", P_FF, FL, -1, 8'h00);
    check_idle("hold_end");

    // Low-weight word 03
    in_data  = 8'h03;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame("w03", P_03, FL, -1, 8'h00);
    check_idle("w03_end");

    // Reset on bit 4 aborts the frame
    in_data  = 8'hB6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_xo%0d", i), 16'(x_out), 16'(P_B6[FL-1-i]));
      if (i == 3) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    check_idle("abort_next");
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("abort_quiet%0d", i), 16'({x_valid, x_out, x_last}), 16'd0);
      step();
    end

    // Reset together with in_valid: word is not accepted
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("rstv_a");
    step();
    check_idle("rstv_b");

    // WIDTH=4 instance, word B
    in_data4  = 4'hB;
    in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    for (int i = 0; i < FL4; i++) begin
      chk($sformatf("w4_xv%0d", i), 16'(x_valid4), 16'd1);
      chk($sformatf("w4_xo%0d", i), 16'(x_out4), 16'(P4_B[FL4-1-i]));
      chk($sformatf("w4_xl%0d", i), 16'(x_last4), 16'(i == FL4 - 1));
      chk($sformatf("w4_rdy%0d", i), 16'(in_ready4), 16'(i == FL4 - 1));
      step();
    end
    chk("w4_end_xv", 16'(x_valid4), 16'd0);
    chk("w4_end_rdy", 16'(in_ready4), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
